// File: rtl/mcycle_ctrl_fsm.sv
// Multicycle controller: fetch/decode/execute sequencing with memory wait states, FPU start/done handshake with timeout, sticky fault.
// Define MCYCLE_CTRL_PERF_EN to add the RetireCnt/StallCnt performance counters.
module mcycle_ctrl_fsm #(
    parameter int FPU_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    input  logic       FPUDone,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       FPUW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       FPUStart,
    output logic       Fault,
    output logic [3:0] StateOut
`ifdef MCYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] RetireCnt,
    output logic [CNT_W-1:0] StallCnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FPUEXEC  = 4'd10,
        S_FPUWB    = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(FPU_TIMEOUT - 1);

    generate
        if (FPU_TIMEOUT < 2 || FPU_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
            $error("mcycle_ctrl_fsm: FPU_TIMEOUT must be 2..255 and CNT_W >= 1");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [7:0] fcnt_q, fcnt_d;

    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        state_d = S_FPUEXEC;
                        fcnt_d  = 8'd0;
                    end
                endcase
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (MemReady) state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_FPUEXEC: begin
                // A completing FPU wins over an expiring timeout in the same cycle.
                fcnt_d = fcnt_q + 8'd1;
                if (FPUDone)                  state_d = S_FPUWB;
                else if (fcnt_q == TMO_LAST)  state_d = S_FAULT;
            end
            S_FPUWB:    state_d = S_FETCH;
            default:    state_d = S_FAULT;
        endcase
    end

`ifdef MCYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             retire_evt, stall_evt;

    always_comb begin
        retire_evt = (state_q inside {S_ALUWB, S_MEMWB, S_BRANCH, S_FPUWB}) ||
                     (state_q == S_MEMWR && MemReady);
        stall_evt  = ((state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !MemReady) ||
                     (state_q == S_FPUEXEC && !FPUDone);
        retire_cnt_d = retire_cnt_q + CNT_W'(retire_evt);
        stall_cnt_d  = stall_cnt_q + CNT_W'(stall_evt);
    end

    assign RetireCnt = retire_cnt_q;
    assign StallCnt  = stall_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            fcnt_q       <= 8'd0;
`ifdef MCYCLE_CTRL_PERF_EN
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
`ifdef MCYCLE_CTRL_PERF_EN
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    // MemW and FPUStart are masked by reset so an aborted access or launch never escapes.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        FPUW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        FPUStart  = 1'b0;
        Fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUOp   = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_ALUWB:    RegW = 1'b1;
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMRD:    AdrSrc = 1'b1;
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = ~reset;
            end
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
            S_FPUEXEC:  FPUStart = (fcnt_q == 8'd0) && !reset;
            S_FPUWB: begin
                FPUW = 1'b1;
                RegW = 1'b1;
            end
            default:    Fault = 1'b1;
        endcase
    end

    assign StateOut = state_q;

endmodule
